// File: rtl/workday_pkg.sv
// ---------------------------------------------------------------------------
// workday_pkg
// Shared types and helpers for the working-day sequencer.
//   day_e      : weekday encoding, SUNDAY=1 .. SATURDAY=7 (0 is not a day)
//   state_e    : sequencer FSM states
//   DEF_DAYS_IN_MONTH : default month length used by the sequencer and step
//   is_weekend : SAT/SUN test
//   inc_week   : next weekday with SAT -> SUN wrap
// ---------------------------------------------------------------------------
package workday_pkg;

  localparam int DEF_DAYS_IN_MONTH = 30;

  typedef enum logic [2:0] {
    SUNDAY    = 3'd1,
    MONDAY    = 3'd2,
    TUESDAY   = 3'd3,
    WEDNESDAY = 3'd4,
    THURSDAY  = 3'd5,
    FRIDAY    = 3'd6,
    SATURDAY  = 3'd7
  } day_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADV  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_weekend(day_e d);
    return (d == SATURDAY) || (d == SUNDAY);
  endfunction

  function automatic day_e inc_week(day_e d);
    logic [2:0] w;
    w = d;
    if (d == SATURDAY) begin
      return SUNDAY;
    end
    w = w + 3'd1;
    return day_e'(w);
  endfunction

endpackage

// File: rtl/workday_step.sv
// ---------------------------------------------------------------------------
// workday_step
// Combinational one-day advance of a (date, weekday) pair.
//   date_cur [4:0] : current date, 1..DAYS_IN_MONTH
//   week_cur [2:0] : current weekday, SUN=1..SAT=7
//   date_nxt [4:0] : following date, DAYS_IN_MONTH wraps to 1
//   week_nxt [2:0] : following weekday, SAT wraps to SUN
// ---------------------------------------------------------------------------
module workday_step
  import workday_pkg::*;
#(
  parameter int DAYS_IN_MONTH = workday_pkg::DEF_DAYS_IN_MONTH
) (
  input  logic [4:0] date_cur,
  input  logic [2:0] week_cur,
  output logic [4:0] date_nxt,
  output logic [2:0] week_nxt
);

  localparam logic [4:0] LAST_DATE = 5'(DAYS_IN_MONTH);

  always_comb begin
    date_nxt = (date_cur == LAST_DATE) ? 5'd1 : date_cur + 5'd1;
    week_nxt = inc_week(day_e'(week_cur));
  end

endmodule

// File: rtl/workday_sequencer.sv
// ---------------------------------------------------------------------------
// workday_sequencer
// Computes the first working day reached after advancing N calendar days
// from a start date/weekday, one day per clock, then skipping non-working
// days (SAT/SUN, plus captured holidays when WORKDAY_HOLIDAY_EN is defined).
//
// Optional feature macro: WORKDAY_HOLIDAY_EN
//   defined   : holiday_mask port exists; a set bit i-1 marks date i as a
//               holiday; more than MAX_SKIP skipped days reports err.
//   undefined : only SAT/SUN are non-working.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request strobe, accepted only in IDLE
//   tod_in [4:0] : start date, 1..DAYS_IN_MONTH
//   week_in[2:0] : start weekday, SUN=1..SAT=7
//   N_in         : calendar days to advance
//   holiday_mask : holiday bitmap (WORKDAY_HOLIDAY_EN only)
//   busy         : request in progress (ADV and DONE states)
//   done         : one-cycle result strobe
//   err          : valid with done; invalid input or skip limit exceeded
//   date_out     : result date (held on err)
//   week_out     : result weekday (held on err)
// ---------------------------------------------------------------------------
module workday_sequencer
  import workday_pkg::*;
#(
  parameter int DAYS_IN_MONTH = DEF_DAYS_IN_MONTH,
  parameter int N_WIDTH       = 3,
  parameter int MAX_SKIP      = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               tod_in,
  input  logic [2:0]               week_in,
  input  logic [N_WIDTH-1:0]       N_in,
`ifdef WORKDAY_HOLIDAY_EN
  input  logic [DAYS_IN_MONTH-1:0] holiday_mask,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [4:0]               date_out,
  output logic [2:0]               week_out
);

  localparam int                SKIP_W     = $clog2(MAX_SKIP + 1) + 1;
  localparam logic [4:0]        LAST_DATE  = 5'(DAYS_IN_MONTH);
  localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(MAX_SKIP);

  state_e              state, state_nxt;

  logic [4:0]          date_r;
  logic [2:0]          week_r;
  logic [N_WIDTH-1:0]  cnt_r;
  logic [SKIP_W-1:0]   skip_r;
`ifdef WORKDAY_HOLIDAY_EN
  logic [DAYS_IN_MONTH-1:0] hol_r;
  logic [4:0]               hol_idx;
`endif

  logic [4:0]          date_nxt;
  logic [2:0]          week_nxt;

  logic                bad_input;
  logic                non_working;

  // FSM control strobes for the datapath and result registers
  logic                load;
  logic                step;
  logic                count;
  logic                skip_inc;
  logic                fin_ok;
  logic                fin_err;

  assign bad_input = (tod_in == 5'd0) || (tod_in > LAST_DATE) || (week_in == 3'd0);

`ifdef WORKDAY_HOLIDAY_EN
  // date_r is always 1..DAYS_IN_MONTH while in ADV, so the index is in range
  assign hol_idx     = date_r - 5'd1;
  assign non_working = is_weekend(day_e'(week_r)) || hol_r[hol_idx];
`else
  assign non_working = is_weekend(day_e'(week_r));
`endif

  workday_step #(
    .DAYS_IN_MONTH (DAYS_IN_MONTH)
  ) u_step (
    .date_cur (date_r),
    .week_cur (week_r),
    .date_nxt (date_nxt),
    .week_nxt (week_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    count     = 1'b0;
    skip_inc  = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (bad_input) begin
            fin_err   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = ADV;
          end
        end
      end
      ADV: begin
        busy = 1'b1;
        if (cnt_r != '0) begin
          step  = 1'b1;
          count = 1'b1;
        end else if (non_working) begin
          // Taking one more skip would exceed the limit: give up with err
          if (skip_r == SKIP_LIMIT) begin
            fin_err   = 1'b1;
            state_nxt = DONE;
          end else begin
            step     = 1'b1;
            skip_inc = 1'b1;
          end
        end else begin
          fin_ok    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_r <= '0;
      week_r <= '0;
      cnt_r  <= '0;
      skip_r <= '0;
`ifdef WORKDAY_HOLIDAY_EN
      hol_r  <= '0;
`endif
    end else if (load) begin
      date_r <= tod_in;
      week_r <= week_in;
      cnt_r  <= N_in;
      skip_r <= '0;
`ifdef WORKDAY_HOLIDAY_EN
      hol_r  <= holiday_mask;
`endif
    end else begin
      if (step) begin
        date_r <= date_nxt;
        week_r <= week_nxt;
      end
      if (count) begin
        cnt_r <= cnt_r - N_WIDTH'(1);
      end
      if (skip_inc) begin
        skip_r <= skip_r + SKIP_W'(1);
      end
    end
  end

  // Results are written on the edge entering DONE so they are valid
  // alongside done; an error leaves the previous date/weekday in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_out <= '0;
      week_out <= '0;
      err      <= 1'b0;
    end else if (fin_ok) begin
      date_out <= date_r;
      week_out <= week_r;
      err      <= 1'b0;
    end else if (fin_err) begin
      err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_workday_sequencer.sv
// ---------------------------------------------------------------------------
// tb_workday_sequencer
// Scoreboard bench for workday_sequencer. Requests push their expected
// result and done cycle; a negedge monitor pops and compares on every done.
// Holiday cases are built only when WORKDAY_HOLIDAY_EN is defined.
// ---------------------------------------------------------------------------
module tb_workday_sequencer;

  localparam int DIM      = 30;
  localparam int MAX_SKIP = 7;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  tod_in  = '0;
  logic [2:0]  week_in = '0;
  logic [2:0]  N_in    = '0;
  logic [DIM-1:0] holiday_mask = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  date_out;
  logic [2:0]  week_out;

  workday_sequencer #(
    .DAYS_IN_MONTH (DIM),
    .N_WIDTH       (3),
    .MAX_SKIP      (MAX_SKIP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .tod_in       (tod_in),
    .week_in      (week_in),
    .N_in         (N_in),
`ifdef WORKDAY_HOLIDAY_EN
    .holiday_mask (holiday_mask),
`endif
    .busy         (busy),
    .done         (done),
    .err          (err),
    .date_out     (date_out),
    .week_out     (week_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int date;
    int week;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_d   = 0;
  int   last_w   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("date_out", date_out, e.date);
        check_eq("week_out", week_out, e.week);
        check_eq("err", err, e.err);
        check_eq("done_cycle", cyc, e.cyc);
        check_eq("busy_at_done", busy, 1'b1);
      end
    end
  end

  // Reference model: plain day-by-day walk using modular arithmetic
  task automatic model(input int tod, input int wk, input int n,
                       output int od, output int ow, output int oe, output int olat);
    int d;
    int w;
    int s;
    if (tod < 1 || tod > DIM || wk < 1) begin
      od = last_d; ow = last_w; oe = 1; olat = 1;
      return;
    end
    d = tod; w = wk;
    for (int i = 0; i < n; i++) begin
      d = d % DIM + 1;
      w = w % 7 + 1;
    end
    s = 0; oe = 0;
    while (w == 1 || w == 7 || holiday_mask[d-1]) begin
      if (s == MAX_SKIP) begin
        oe = 1;
        break;
      end
      d = d % DIM + 1;
      w = w % 7 + 1;
      s++;
    end
    olat = n + s + 2;
    if (oe != 0) begin
      od = last_d; ow = last_w;
    end else begin
      od = d; ow = w;
    end
  endtask

  task automatic send(input int tod, input int wk, input int n,
                      input int ed, input int ew, input int ee, input int elat,
                      input bit poke_busy, input bit poke_done);
    int   k;
    int   t;
    exp_t e;
    @(negedge clk);
    tod_in  = 5'(tod);
    week_in = 3'(wk);
    N_in    = 3'(n);
    start   = 1'b1;
    k = cyc;
    e.date = ed; e.week = ew; e.err = ee; e.cyc = k + elat;
    sb.push_back(e);
    if (ee == 0) begin
      last_d = ed; last_w = ew;
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1'b1);
    if (poke_busy) begin
      tod_in = 5'd3; week_in = 3'd4; N_in = 3'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (poke_done) begin
      t = 0;
      while (cyc < k + elat && t < 100) begin
        @(negedge clk);
        t++;
      end
      tod_in = 5'd31;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    check_eq("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_date", date_out, 5'd0);
    check_eq("rst_week", week_out, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // Directed cases: N steps, weekend skips, month wrap, N=0 on Sunday
    send(10, 2, 3, 13, 5, 0, 5, 1'b0, 1'b0);
    send(12, 5, 2, 16, 2, 0, 6, 1'b0, 1'b0);
    send(29, 6, 1,  2, 2, 0, 5, 1'b0, 1'b0);
    send( 5, 1, 0,  6, 2, 0, 3, 1'b0, 1'b0);

    // Invalid input keeps previous result; start during DONE is ignored
    send(31, 3, 2, 6, 2, 1, 1, 1'b1, 1'b0);
    send( 7, 0, 2, 6, 2, 1, 1, 1'b0, 1'b0);
    send( 0, 4, 1, 6, 2, 1, 1, 1'b0, 1'b0);

    // Start while busy in ADV, and start in the done cycle, are ignored
    send(10, 2, 3, 13, 5, 0, 5, 1'b1, 1'b0);
    send(12, 5, 2, 16, 2, 0, 6, 1'b0, 1'b1);

    // Asynchronous reset in the middle of ADV aborts with no done
    @(negedge clk);
    tod_in = 5'd10; week_in = 3'd2; N_in = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_err", err, 1'b0);
    check_eq("abort_date", date_out, 5'd0);
    check_eq("abort_week", week_out, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_d = 0; last_w = 0;
    repeat (8) @(negedge clk);
    send(10, 2, 3, 13, 5, 0, 5, 1'b0, 1'b0);

`ifdef WORKDAY_HOLIDAY_EN
    // Holiday on date 13 pushes the result to Friday 14
    holiday_mask = DIM'(1) << 12;
    send(10, 2, 3, 14, 6, 0, 6, 1'b0, 1'b0);
    // Every date a holiday: skip limit reached, err after MAX_SKIP skips
    holiday_mask = '1;
    send(1, 2, 0, 14, 6, 1, MAX_SKIP + 2, 1'b0, 1'b0);
    holiday_mask = '0;
`endif

    // Randomised requests checked against the reference model
    for (int i = 0; i < 24; i++) begin
      int tod;
      int wk;
      int n;
      int ed;
      int ew;
      int ee;
      int el;
      tod = int'($urandom_range(0, 31));
      wk  = int'($urandom_range(0, 7));
      n   = int'($urandom_range(0, 7));
`ifdef WORKDAY_HOLIDAY_EN
      holiday_mask = DIM'($urandom() & $urandom());
`endif
      model(tod, wk, n, ed, ew, ee, el);
      send(tod, wk, n, ed, ew, ee, el, 1'b0, 1'b0);
    end
    holiday_mask = '0;

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
